// File: rtl/video_pkg.sv
// Shared constants, types and helpers for the video pattern source.
package video_pkg;

  localparam logic [3:0] PKT_CTRL  = 4'hF;
  localparam logic [3:0] PKT_VIDEO = 4'h0;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_COLOUR = 3'd1;
  localparam logic [2:0] ADDR_BOXPOS = 3'd2;
  localparam logic [2:0] ADDR_FRAMES = 3'd3;
  localparam logic [2:0] ADDR_ID     = 3'd4;

  localparam logic [31:0] VPS_ID = 32'h1234EEE3;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_SOLID = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_BOX   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_VHDR,
    ST_PIX,
    ST_GAP
  } vps_state_e;

  // Per-frame configuration, frozen at frame start.
  typedef struct packed {
    logic [1:0]  pattern;
    logic [23:0] colour;
    logic [10:0] box_x;
    logic [10:0] box_y;
  } cfg_t;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hffffff;
      3'd1:    c = 24'hffff00;
      3'd2:    c = 24'h00ffff;
      3'd3:    c = 24'h00ff00;
      3'd4:    c = 24'hff00ff;
      3'd5:    c = 24'hff0000;
      3'd6:    c = 24'h0000ff;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Control packet beat k; nibble 0 is the top nibble of the 16-bit width.
  function automatic logic [23:0] ctrl_beat(input logic [1:0] k, input logic [10:0] w,
                                            input logic [10:0] h);
    logic [35:0] nib;
    logic [23:0] beat;
    int          base;
    nib  = {4'h0, h[3:0], h[7:4], {1'b0, h[10:8]}, 4'h0,
            w[3:0], w[7:4], {1'b0, w[10:8]}, 4'h0};
    beat = '0;
    if (k == 2'd0) begin
      beat = {20'd0, PKT_CTRL};
    end else begin
      base = 3 * (int'(k) - 1);
      for (int s = 0; s < 3; s++) begin
        beat[8*s +: 4] = nib[4*(base+s) +: 4];
      end
    end
    return beat;
  endfunction

endpackage

// File: rtl/vps_pixel_gen.sv
// Pixel colour from raster position and frozen frame configuration.
// Combinational, zero latency; no flow control of its own.
module vps_pixel_gen
  import video_pkg::*;
#(
  parameter logic [10:0] BOX_SIZE = 11'd32
) (
  input  logic [1:0]  pattern,
  input  logic [23:0] colour,
  input  logic [10:0] box_x,
  input  logic [10:0] box_y,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [2:0]  bar,
  input  logic [7:0]  frame_lo,
  output logic [23:0] rgb
);

  logic [11:0] bx_end;
  logic [11:0] by_end;
  logic        in_box;

  always_comb begin
    // 12-bit ends so a box near the frame edge clips instead of wrapping.
    bx_end = {1'b0, box_x} + {1'b0, BOX_SIZE};
    by_end = {1'b0, box_y} + {1'b0, BOX_SIZE};
    in_box = (x >= box_x) && ({1'b0, x} < bx_end) &&
             (y >= box_y) && ({1'b0, y} < by_end);
    rgb = '0;
    case (pattern)
      PAT_BARS:  rgb = bar_colour(bar);
      PAT_SOLID: rgb = colour;
      PAT_GRAD:  rgb = {x[7:0], y[7:0], frame_lo};
      PAT_BOX:   rgb = in_box ? colour : 24'h000000;
      default:   rgb = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// Avalon-ST test-pattern video source (control packet + video packet per frame) with MM config.
// Registered outputs, one beat per cycle at full rate; beats hold stable while source_ready is low.
module video_pattern_source
  import video_pkg::*;
#(
  parameter logic [10:0] IMAGE_W         = 11'd640,
  parameter logic [10:0] IMAGE_H         = 11'd480,
  parameter logic [10:0] BOX_SIZE        = 11'd32,
  parameter int          FRAME_GAP       = 16,
  parameter logic [23:0] BOX_COL_DEFAULT = 24'hff00ff
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop
);

  localparam logic [10:0] X_LAST     = IMAGE_W - 11'd1;
  localparam logic [10:0] Y_LAST     = IMAGE_H - 11'd1;
  localparam logic [10:0] BAR_LEN_M1 = IMAGE_W / 11'd8 - 11'd1;
  localparam logic [15:0] GAP_LAST   = 16'(FRAME_GAP - 1);

  vps_state_e  state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [23:0] colour_q, colour_d;
  logic [10:0] box_x_q, box_x_d;
  logic [10:0] box_y_q, box_y_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  cfg_t        cfg_q, cfg_d;
  logic [1:0]  beat_q, beat_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [2:0]  bar_q, bar_d;
  logic [10:0] bar_cnt_q, bar_cnt_d;
  logic [15:0] gap_q, gap_d;
  logic        src_vld_q, src_vld_d;
  logic [23:0] src_dat_q, src_dat_d;
  logic        src_sop_q, src_sop_d;
  logic        src_eop_q, src_eop_d;

  logic        load;
  logic        xfer;
  logic        last_pix;
  logic        frame_done;
  logic        mm_wr;
  logic        mm_rd;
  logic [23:0] pix_rgb;
  logic        unused_wdata;

  assign load     = ~src_vld_q | source_ready;
  assign xfer     = src_vld_q & source_ready;
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  // The video eop beat is always accepted while the FSM already sits in GAP.
  assign frame_done   = xfer & src_eop_q & (state_q == ST_GAP);
  assign mm_wr        = s_chipselect & s_write;
  assign mm_rd        = s_chipselect & s_read;
  assign unused_wdata = ^s_writedata[31:27];

  vps_pixel_gen #(
    .BOX_SIZE (BOX_SIZE)
  ) u_pixel_gen (
    .pattern  (cfg_q.pattern),
    .colour   (cfg_q.colour),
    .box_x    (cfg_q.box_x),
    .box_y    (cfg_q.box_y),
    .x        (x_q),
    .y        (y_q),
    .bar      (bar_q),
    .frame_lo (frame_cnt_q[7:0]),
    .rgb      (pix_rgb)
  );

  always_comb begin
    ctrl_d      = ctrl_q;
    colour_d    = colour_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    frame_cnt_d = frame_cnt_q + {31'd0, frame_done};
    rdata_d     = rdata_q;
    if (mm_wr) begin
      case (s_address)
        ADDR_CTRL:   ctrl_d = s_writedata[2:0];
        ADDR_COLOUR: colour_d = s_writedata[23:0];
        ADDR_BOXPOS: begin
          box_x_d = s_writedata[26:16];
          box_y_d = s_writedata[10:0];
        end
        default: ;
      endcase
    end
    if (mm_rd) begin
      case (s_address)
        ADDR_CTRL:   rdata_d = {29'd0, ctrl_q};
        ADDR_COLOUR: rdata_d = {8'd0, colour_q};
        ADDR_BOXPOS: rdata_d = {5'd0, box_x_q, 5'd0, box_y_q};
        ADDR_FRAMES: rdata_d = frame_cnt_q;
        ADDR_ID:     rdata_d = VPS_ID;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ctrl_q[0]) state_d = ST_CTRL;
      ST_CTRL: if (load && beat_q == 2'd3) state_d = ST_VHDR;
      ST_VHDR: if (load) state_d = ST_PIX;
      ST_PIX:  if (load && last_pix) state_d = ST_GAP;
      ST_GAP:  if (!src_vld_q && gap_q == GAP_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A new beat is produced only when the output register is empty or draining.
  always_comb begin
    cfg_d     = cfg_q;
    beat_d    = beat_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_d     = bar_q;
    bar_cnt_d = bar_cnt_q;
    gap_d     = gap_q;
    src_vld_d = src_vld_q;
    src_dat_d = src_dat_q;
    src_sop_d = src_sop_q;
    src_eop_d = src_eop_q;
    if (load) begin
      src_vld_d = 1'b0;
      src_dat_d = '0;
      src_sop_d = 1'b0;
      src_eop_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        beat_d    = '0;
        x_d       = '0;
        y_d       = '0;
        bar_d     = '0;
        bar_cnt_d = '0;
        gap_d     = '0;
        if (ctrl_q[0]) begin
          cfg_d.pattern = ctrl_q[2:1];
          cfg_d.colour  = colour_q;
          cfg_d.box_x   = box_x_q;
          cfg_d.box_y   = box_y_q;
        end
      end
      ST_CTRL: if (load) begin
        src_vld_d = 1'b1;
        src_dat_d = ctrl_beat(beat_q, IMAGE_W, IMAGE_H);
        src_sop_d = (beat_q == 2'd0);
        src_eop_d = (beat_q == 2'd3);
        beat_d    = beat_q + 2'd1;
      end
      ST_VHDR: if (load) begin
        src_vld_d = 1'b1;
        src_dat_d = {20'd0, PKT_VIDEO};
        src_sop_d = 1'b1;
      end
      ST_PIX: if (load) begin
        src_vld_d = 1'b1;
        src_dat_d = pix_rgb;
        src_eop_d = last_pix;
        if (x_q == X_LAST) begin
          x_d       = '0;
          y_d       = y_q + 11'd1;
          bar_d     = '0;
          bar_cnt_d = '0;
        end else begin
          x_d = x_q + 11'd1;
          if (bar_cnt_q == BAR_LEN_M1) begin
            bar_cnt_d = '0;
            bar_d     = bar_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + 11'd1;
          end
        end
      end
      ST_GAP: if (!src_vld_q) gap_d = gap_q + 16'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= '0;
      colour_q    <= BOX_COL_DEFAULT;
      box_x_q     <= '0;
      box_y_q     <= '0;
      frame_cnt_q <= '0;
      rdata_q     <= '0;
      cfg_q       <= '0;
      beat_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bar_q       <= '0;
      bar_cnt_q   <= '0;
      gap_q       <= '0;
      src_vld_q   <= 1'b0;
      src_dat_q   <= '0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      colour_q    <= colour_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      frame_cnt_q <= frame_cnt_d;
      rdata_q     <= rdata_d;
      cfg_q       <= cfg_d;
      beat_q      <= beat_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bar_q       <= bar_d;
      bar_cnt_q   <= bar_cnt_d;
      gap_q       <= gap_d;
      src_vld_q   <= src_vld_d;
      src_dat_q   <= src_dat_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
    end
  end

  assign s_readdata   = rdata_q;
  assign source_data  = src_dat_q;
  assign source_valid = src_vld_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Scoreboard bench: frames are predicted from the register settings and checked beat by beat.
module tb_video_pattern_source;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int BOX = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_chipselect, s_read, s_write;
  logic [2:0]  s_address;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [23:0] source_data;
  logic        source_valid, source_ready, source_sop, source_eop;

  always #5 clk = ~clk;

  video_pattern_source #(
    .IMAGE_W         (11'd16),
    .IMAGE_H         (11'd4),
    .BOX_SIZE        (11'd2),
    .FRAME_GAP       (4),
    .BOX_COL_DEFAULT (24'hff00ff)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_chipselect (s_chipselect),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_address    (s_address),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop)
  );

  typedef struct {
    logic [23:0] d;
    logic        sop;
    logic        eop;
    logic        vid;
  } beat_t;

  beat_t       exp_q[$];
  int          n_vec = 0, n_err = 0;
  int          vid_sop_seen = 0, frames_seen = 0, model_frames = 0;
  int          ready_pct = 100;
  logic [23:0] bar_tab [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                               24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic push_beat(input logic [23:0] d, input logic sop, input logic eop, input logic vid);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop; b.vid = vid;
    exp_q.push_back(b);
  endtask

  function automatic logic [23:0] model_pix(input int pat, input int x, input int y,
                                            input logic [23:0] col, input int bx, input int by,
                                            input int fc);
    case (pat)
      0: return bar_tab[x / (W / 8)];
      1: return col;
      2: return {8'(x % 256), 8'(y % 256), 8'(fc % 256)};
      3: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? col : 24'h000000;
      default: return 24'h0;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [23:0] col, input int bx, input int by);
    int nib[9];
    for (int i = 0; i < 4; i++) begin
      nib[i]     = (W >> (12 - 4 * i)) & 15;
      nib[4 + i] = (H >> (12 - 4 * i)) & 15;
    end
    nib[8] = 0;
    push_beat(24'h00000F, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      logic [23:0] b;
      b = '0;
      for (int s = 0; s < 3; s++) b = b | (24'(nib[3 * (k - 1) + s]) << (8 * s));
      push_beat(b, 1'b0, k == 3, 1'b0);
    end
    push_beat(24'h000000, 1'b1, 1'b0, 1'b1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        push_beat(model_pix(pat, x, y, col, bx, by, model_frames), 1'b0,
                  (x == W - 1) && (y == H - 1), 1'b1);
    model_frames++;
  endtask

  task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic mm_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(posedge clk);
    #1 d = s_readdata;
    @(negedge clk);
    s_chipselect = 1'b0; s_read = 1'b0;
  endtask

  task automatic wait_sop(input int target);
    for (int i = 0; i < 5000 && vid_sop_seen < target; i++) @(posedge clk);
    chk("wait_video_sop", 32'(vid_sop_seen >= target), 32'd1);
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 5000 && frames_seen < target; i++) @(posedge clk);
    chk("wait_frame_done", 32'(frames_seen >= target), 32'd1);
  endtask

  task automatic drain(input string nm);
    repeat (40) @(posedge clk);
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  always begin
    @(posedge clk);
    #1 source_ready = ($urandom_range(99) < ready_pct);
  end

  logic        stall_prev = 1'b0;
  logic [26:0] held;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_while_stalled", {5'd0, source_valid, source_sop, source_eop, source_data},
            {5'd0, held});
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data %h sop %b eop %b with nothing expected",
                   source_data, source_sop, source_eop);
        end else begin
          beat_t w;
          w = exp_q.pop_front();
          chk("beat", {6'd0, source_sop, source_eop, source_data}, {6'd0, w.sop, w.eop, w.d});
          if (w.vid && w.sop) vid_sop_seen++;
          if (w.vid && w.eop) frames_seen++;
        end
      end
      stall_prev = source_valid && !source_ready;
      held       = {source_valid, source_sop, source_eop, source_data};
    end
  end

  initial begin
    logic [31:0] rd;
    logic [23:0] c1, c2;
    int          base;
    reset_n = 1'b0;
    s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
    s_address = '0; s_writedata = '0;
    source_ready = 1'b1;
    #2;
    chk("reset_outputs", {5'd0, source_valid, source_sop, source_eop, source_data}, 32'd0);
    chk("reset_readdata", s_readdata, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    mm_read(3'd1, rd); chk("colour_default", rd, 32'h00ff00ff);
    mm_read(3'd0, rd); chk("ctrl_default", rd, 32'd0);
    mm_read(3'd4, rd); chk("id", rd, 32'h1234EEE3);
    mm_write(3'd4, 32'hdeadbeef);
    mm_read(3'd4, rd); chk("id_ignores_write", rd, 32'h1234EEE3);
    mm_write(3'd6, 32'h12345678);
    mm_read(3'd6, rd); chk("unmapped_reads_zero", rd, 32'd0);

    // Bars at full rate; enable cleared partway through the pixels.
    base = frames_seen;
    push_frame(0, 24'h0, 0, 0);
    mm_write(3'd0, 32'h1);
    wait_sop(vid_sop_seen + 1);
    repeat (10) @(posedge clk);
    mm_write(3'd0, 32'h0);
    wait_frames(base + 1);
    drain("bars_drain");
    mm_read(3'd3, rd); chk("frames_after_bars", rd, 32'(model_frames));

    // Box at (4,1) in the default colour under random backpressure.
    ready_pct = 50;
    mm_write(3'd2, {5'd0, 11'd4, 5'd0, 11'd1});
    mm_read(3'd2, rd); chk("boxpos_readback", rd, {5'd0, 11'd4, 5'd0, 11'd1});
    base = frames_seen;
    push_frame(3, 24'hff00ff, 4, 1);
    mm_write(3'd0, 32'h7);
    wait_sop(vid_sop_seen + 1);
    mm_write(3'd0, 32'h0);
    wait_frames(base + 1);
    drain("box_drain");

    // Gradient carries the completed-frame count in blue.
    base = frames_seen;
    push_frame(2, 24'h0, 0, 0);
    mm_write(3'd0, 32'h5);
    wait_sop(vid_sop_seen + 1);
    mm_write(3'd0, 32'h0);
    wait_frames(base + 1);
    drain("gradient_drain");

    // Box hanging off the bottom-right corner clips to one pixel.
    c1 = 24'($urandom) | 24'h010101;
    mm_write(3'd1, {8'd0, c1});
    mm_write(3'd2, {5'd0, 11'd15, 5'd0, 11'd3});
    base = frames_seen;
    push_frame(3, c1, 15, 3);
    mm_write(3'd0, 32'h7);
    wait_sop(vid_sop_seen + 1);
    mm_write(3'd0, 32'h0);
    wait_frames(base + 1);
    drain("box_clip_drain");

    // Solid colour rewritten mid-frame: only the following frame sees it.
    ready_pct = 100;
    c1 = 24'($urandom);
    c2 = ~c1;
    mm_write(3'd1, {8'd0, c1});
    base = frames_seen;
    push_frame(1, c1, 0, 0);
    push_frame(1, c2, 0, 0);
    mm_write(3'd0, 32'h3);
    wait_sop(vid_sop_seen + 1);
    mm_write(3'd1, {8'd0, c2});
    wait_sop(vid_sop_seen + 1);
    mm_write(3'd0, 32'h0);
    wait_frames(base + 2);
    drain("solid_drain");
    mm_read(3'd3, rd); chk("frames_total", rd, 32'(model_frames));
    mm_read(3'd4, rd); chk("id_after_frames", rd, 32'h1234EEE3);

    // Reset in the middle of a frame.
    push_frame(0, 24'h0, 0, 0);
    mm_write(3'd0, 32'h1);
    wait_sop(vid_sop_seen + 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("midframe_reset_outputs",
           {5'd0, source_valid, source_sop, source_eop, source_data}, 32'd0);
    exp_q.delete();
    model_frames = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    mm_read(3'd3, rd); chk("frames_after_reset", rd, 32'd0);
    mm_read(3'd1, rd); chk("colour_after_reset", rd, 32'h00ff00ff);
    mm_read(3'd0, rd); chk("ctrl_after_reset", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_pattern_source.md
Name: video_pattern_source

Overview:
- Avalon-ST video transmitter; the producing end of the 24-bit RGB video stream that the image-processing pipeline consumes.
- Emits one control packet and then one video packet per frame. Content is a CPU-selected test pattern, configured over an Avalon-MM slave.
- Drives the image processor directly in camera-less bring-up and bench runs. Its moving-box pattern is a known-position stimulus for colour-target detection.

Parameters:
- IMAGE_W, 11'd640: active pixels per line; must be divisible by 8.
- IMAGE_H, 11'd480: lines per frame.
- BOX_SIZE, 11'd32: side length of the box pattern, in pixels.
- FRAME_GAP, 16: idle cycles between frames (eop of video packet to sop of the next control packet).
- BOX_COL_DEFAULT, 24'hff00ff: reset value of the pattern colour register.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- s_chipselect  in  1  MM slave select
- s_read  in  1  MM read strobe
- s_write  in  1  MM write strobe
- s_address  in  3  MM word address
- s_writedata  in  32  MM write data
- s_readdata  out  32  MM read data, registered
- source_data  out  24  {R[23:16],G[15:8],B[7:0]}; symbol s occupies bits [8s+7:8s]
- source_valid  out  1  beat valid
- source_ready  in  1  downstream ready
- source_sop  out  1  first beat of packet
- source_eop  out  1  last beat of packet

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values: all outputs 0; FSM IDLE; ctrl=0; colour=BOX_COL_DEFAULT; box_pos=0; frame_count=0.
- Registers:
  - addr 0 CTRL RW: bit0 enable, bits[2:1] pattern.
  - addr 1 COLOUR RW: bits[23:0].
  - addr 2 BOXPOS RW: {5'b0,x[10:0],5'b0,y[10:0]}.
  - addr 3 FRAMES RO: 32-bit count of completed video packets.
  - addr 4 ID RO: 32'h1234EEE3.
  - Other addresses read 0 and ignore writes.
  - s_readdata updates the cycle after s_chipselect&s_read; zero wait states.
- Output register:
  - source_* are registered.
  - While source_valid=1 and source_ready=0, data/sop/eop/valid hold stable.
  - A beat transfers on valid&ready.
  - The next beat may be presented the cycle after a transfer, so full throughput is 1 beat/cycle.
- FSM: IDLE -> CTRL -> VHDR -> PIX -> GAP -> IDLE.
  - IDLE: if enable=1, snapshot pattern, colour and box_pos into shadow registers. Next cycle, present CTRL beat 0. MM writes during a frame do not affect it.
  - CTRL: 4 beats.
    - Beat 0 = 24'h00000F with sop.
    - Nibbles n0..n8 = W[15:12],W[11:8],W[7:4],W[3:0],H[15:12],H[11:8],H[7:4],H[3:0],4'h0 (W, H zero-extended to 16 bits).
    - Beat k (k=1..3), symbol s carries n[3(k-1)+s] in bits [8s+3:8s]; other bits 0.
    - Beat 3 has eop.
  - VHDR: 1 beat, 24'h000000 with sop.
  - PIX: IMAGE_W*IMAGE_H beats, raster order.
    - x counts 0..IMAGE_W-1; y increments when x wraps.
    - eop on x=IMAGE_W-1, y=IMAGE_H-1.
    - On the eop transfer: frame_count += 1 (wraps at 2^32).
  - GAP: FRAME_GAP cycles with valid=0, then IDLE.
- Disabling: clearing enable mid-frame finishes the current frame. No truncated packets are ever emitted.
- Patterns (shadow copy):
  - 0 bars: bar = x/(IMAGE_W/8), from a divide-free counter. Colours: ffffff, ffff00, 00ffff, 00ff00, ff00ff, ff0000, 0000ff, 000000.
  - 1 solid: the colour register.
  - 2 gradient: {x[7:0], y[7:0], frame_count[7:0]}.
  - 3 box: colour where bx<=x<bx+BOX_SIZE and by<=y<by+BOX_SIZE, else 000000. Compare in 12 bits so edges near the frame end clip, not wrap.
- Reset mid-frame: outputs drop to 0 immediately; the stream restarts from IDLE.

Decomposition:
- Shared package video_pkg:
  - packet type constants PKT_CTRL=4'hF, PKT_VIDEO=4'h0
  - register address constants
  - FSM state enum
  - bar colour table
- One natural sub-module: vps_pixel_gen. It is combinational or one-stage logic (x, y, shadow config, frame_count -> RGB).
- The FSM, counters and output register stay in the top module.

Test Plan:
- W=640, H=480, enable, ready=1 -> CTRL beats 00000F(sop), 080200, 010000, 00000E(eop); then 000000(sop); then 307200 pixels, eop on the last.
- W=16, H=4, pattern 0 -> pixels 0-1 ffffff, 2-3 ffff00, ..., 14-15 000000, on every line.
- Pattern 3, BOXPOS x=4 y=1, BOX_SIZE=2, colour ff00ff -> ff00ff only at (4..5, 1..2); all other pixels 000000.
- Random source_ready (~50%) -> no data/sop/eop change while valid&~ready; beat count identical to the ready=1 run.
- Clear enable mid-PIX -> frame completes with eop; FRAMES +1; no further sop after GAP.
- Write COLOUR mid-frame with pattern 1 -> current frame keeps the old colour; the next frame uses the new one. Read ID -> 1234EEE3 one cycle after the read.
